cache_arbiter: RTL and testbench

- Shares the single physical-memory line port between the instruction cache and the data cache of the pipelined RV32I core.
- Grants one requester at a time and latches that request's address, data and read/write into registers.
- Drives physical memory from those registers until `pmem_resp`, then routes the response back to the granted cache.
- Round-robin fairness when both caches are pending; no requester can starve.

---
 rtl/arbiter_types.sv | 22 ++
 rtl/cache_arbiter_if.sv | 38 +++
 rtl/cache_arbiter_control.sv | 69 ++++++
 rtl/cache_arbiter.sv | 75 +++++++
 tb/tb_cache_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/arbiter_types.sv
// Shared types and default widths for the I/D cache line-port arbiter.
package arbiter_types;
  localparam int ARB_ADDR_WIDTH = 32;
  localparam int ARB_LINE_WIDTH = 256;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D,
    ARB_RECOVER
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arb_grant_t;

  typedef enum logic {
    ARB_OP_READ,
    ARB_OP_WRITE
  } arb_op_t;
endpackage

// File: rtl/cache_arbiter_if.sv
// Cache-side and memory-side line ports of the arbiter; the arbiter uses the slave view,
// the caches/memory environment the master view. No backpressure beyond the resp handshake.
interface cache_arbiter_if
  import arbiter_types::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int LINE_WIDTH = ARB_LINE_WIDTH
);
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;
  logic                  arb_busy;

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address,
           pmem_wdata, arb_busy
  );

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address,
           pmem_wdata, arb_busy
  );
endinterface

// File: rtl/cache_arbiter_control.sv
// Arbiter FSM with round-robin last_grant; grants in IDLE, serves until pmem_resp,
// then burns one RECOVER cycle so the served cache can drop its request.
module cache_arbiter_control
  import arbiter_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_i_req,
  input  logic       i_d_req,
  input  logic       i_pmem_resp,
  output logic       o_latch_en,
  output arb_grant_t o_grant,
  output logic       o_done,
  output logic       o_route_i,
  output logic       o_route_d,
  output logic       o_busy
);
  arb_state_t r_state;
  arb_state_t w_next;
  arb_grant_t r_last_grant;

  // On a tie the requester that did not win last time goes next.
  assign o_grant = (i_i_req && (!i_d_req || r_last_grant == GRANT_D)) ? GRANT_I : GRANT_D;
  assign o_busy  = (r_state != ARB_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= GRANT_D;
    end else begin
      r_state <= w_next;
      if (o_latch_en) begin
        r_last_grant <= o_grant;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    o_latch_en = 1'b0;
    o_done     = 1'b0;
    o_route_i  = 1'b0;
    o_route_d  = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (i_i_req || i_d_req) begin
          o_latch_en = 1'b1;
          w_next     = (o_grant == GRANT_I) ? ARB_SERVE_I : ARB_SERVE_D;
        end
      end
      ARB_SERVE_I: begin
        o_route_i = 1'b1;
        if (i_pmem_resp) begin
          o_done = 1'b1;
          w_next = ARB_RECOVER;
        end
      end
      ARB_SERVE_D: begin
        o_route_d = 1'b1;
        if (i_pmem_resp) begin
          o_done = 1'b1;
          w_next = ARB_RECOVER;
        end
      end
      ARB_RECOVER: w_next = ARB_IDLE;
      default:     w_next = ARB_IDLE;
    endcase
  end
endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory line port between I- and D-cache; strobes rise the cycle
// after the grant and hold until pmem_resp. Requests wait while the arbiter is busy.
module cache_arbiter
  import arbiter_types::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int LINE_WIDTH = ARB_LINE_WIDTH
)(
  input logic            clk,
  input logic            rst,
  cache_arbiter_if.slave io_bus
);
  logic                  w_d_req;
  logic                  w_latch_en;
  logic                  w_done;
  logic                  w_route_i;
  logic                  w_route_d;
  logic                  w_busy;
  arb_grant_t            w_grant;
  arb_op_t               w_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic                  r_pmem_read;
  logic                  r_pmem_write;

  assign w_d_req = io_bus.d_read | io_bus.d_write;
  // A D request with both read and write set is treated as a writeback.
  assign w_op = (w_grant == GRANT_D && io_bus.d_write) ? ARB_OP_WRITE : ARB_OP_READ;

  cache_arbiter_control u_control (
    .clk         (clk),
    .rst         (rst),
    .i_i_req     (io_bus.i_read),
    .i_d_req     (w_d_req),
    .i_pmem_resp (io_bus.pmem_resp),
    .o_latch_en  (w_latch_en),
    .o_grant     (w_grant),
    .o_done      (w_done),
    .o_route_i   (w_route_i),
    .o_route_d   (w_route_d),
    .o_busy      (w_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
    end else if (w_latch_en) begin
      r_pmem_read  <= (w_op == ARB_OP_READ);
      r_pmem_write <= (w_op == ARB_OP_WRITE);
      if (w_grant == GRANT_I) begin
        r_addr <= io_bus.i_address;
      end else begin
        r_addr  <= io_bus.d_address;
        r_wdata <= io_bus.d_wdata;
      end
    end else if (w_done) begin
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
    end
  end

  assign io_bus.pmem_read    = r_pmem_read;
  assign io_bus.pmem_write   = r_pmem_write;
  assign io_bus.pmem_address = r_addr;
  assign io_bus.pmem_wdata   = r_wdata;
  assign io_bus.arb_busy     = w_busy;

  assign io_bus.i_resp  = w_route_i & io_bus.pmem_resp;
  assign io_bus.d_resp  = w_route_d & io_bus.pmem_resp;
  assign io_bus.i_rdata = w_route_i ? io_bus.pmem_rdata : '0;
  assign io_bus.d_rdata = w_route_d ? io_bus.pmem_rdata : '0;
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: grant order, latency, latching, reset and spurious resp.
module tb_cache_arbiter;
  import arbiter_types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [255:0] line_a5;
  logic [255:0] line_dead;

  cache_arbiter_if bus ();

  cache_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.d_read && bus.d_write)) else $error("illegal D read+write request");
    end
  end

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic idle_inputs();
    bus.i_read     = 1'b0;
    bus.i_address  = '0;
    bus.d_read     = 1'b0;
    bus.d_write    = 1'b0;
    bus.d_address  = '0;
    bus.d_wdata    = '0;
    bus.pmem_rdata = '0;
    bus.pmem_resp  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  // Advances until a memory strobe is seen; ncyc = cycles advanced.
  task automatic wait_strobe(output int ncyc);
    bit seen;
    seen = 1'b0;
    ncyc = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      nxt();
      settle();
      ncyc++;
      seen = bus.pmem_read | bus.pmem_write;
    end
    check("strobe_timeout", seen, 1'b1);
  endtask

  initial begin
    int  ncyc;
    logic exp_i;
    line_a5   = {32{8'hA5}};
    line_dead = {8{32'hDEADBEEF}};
    idle_inputs();
    do_reset();

    // Reset state
    settle();
    check("rst_busy", bus.arb_busy, 1'b0);
    check("rst_pmem_read", bus.pmem_read, 1'b0);
    check("rst_pmem_write", bus.pmem_write, 1'b0);
    check("rst_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    check("rst_addr", bus.pmem_address, 32'h0);

    // Single I read
    bus.i_read = 1'b1;
    bus.i_address = 32'h60;
    #2;
    check("t1_no_early_strobe", bus.pmem_read, 1'b0);
    nxt(); settle();
    check("t1_pmem_read", bus.pmem_read, 1'b1);
    check("t1_addr", bus.pmem_address, 32'h60);
    check("t1_busy", bus.arb_busy, 1'b1);
    repeat (4) nxt();
    bus.pmem_rdata = line_a5;
    bus.pmem_resp = 1'b1;
    settle();
    check("t1_i_resp", bus.i_resp, 1'b1);
    check("t1_i_rdata", bus.i_rdata, line_a5);
    check("t1_d_resp", bus.d_resp, 1'b0);
    check("t1_d_rdata", bus.d_rdata, 256'h0);
    check("t1_read_held", bus.pmem_read, 1'b1);
    nxt();
    bus.pmem_resp = 1'b0;
    bus.i_read = 1'b0;
    settle();
    check("t1_recover_strobe", bus.pmem_read, 1'b0);
    check("t1_recover_busy", bus.arb_busy, 1'b1);
    check("t1_recover_i_rdata", bus.i_rdata, 256'h0);
    nxt(); settle();
    check("t1_idle_busy", bus.arb_busy, 1'b0);

    // Simultaneous I read and D write after reset: I first
    do_reset();
    bus.i_read = 1'b1;
    bus.i_address = 32'h100;
    bus.d_write = 1'b1;
    bus.d_address = 32'h200;
    bus.d_wdata = line_dead;
    nxt(); settle();
    check("t2_i_first_read", bus.pmem_read, 1'b1);
    check("t2_i_first_write", bus.pmem_write, 1'b0);
    check("t2_i_addr", bus.pmem_address, 32'h100);
    nxt();
    bus.pmem_rdata = {8{32'h0BADF00D}};
    bus.pmem_resp = 1'b1;
    settle();
    check("t2_i_resp", bus.i_resp, 1'b1);
    check("t2_d_resp_quiet", bus.d_resp, 1'b0);
    nxt();
    bus.pmem_resp = 1'b0;
    bus.i_read = 1'b0;
    settle();
    check("t2_recover_write", bus.pmem_write, 1'b0);
    nxt(); settle();
    check("t2_idle_write", bus.pmem_write, 1'b0);
    nxt(); settle();
    check("t2_d_write", bus.pmem_write, 1'b1);
    check("t2_d_read", bus.pmem_read, 1'b0);
    check("t2_d_addr", bus.pmem_address, 32'h200);
    check("t2_d_wdata", bus.pmem_wdata, line_dead);
    bus.pmem_resp = 1'b1;
    #2;
    check("t2_d_resp", bus.d_resp, 1'b1);
    check("t2_i_resp_quiet", bus.i_resp, 1'b0);
    nxt();
    bus.pmem_resp = 1'b0;
    bus.d_write = 1'b0;
    nxt();

    // Both held: grants alternate starting with I, spaced resp->strobe by 3 cycles
    bus.i_read = 1'b1;
    bus.i_address = 32'h1000;
    bus.d_read = 1'b1;
    bus.d_address = 32'h2000;
    for (int k = 0; k < 6; k++) begin
      wait_strobe(ncyc);
      exp_i = ((k % 2) == 0);
      if (k > 0) check("t3_spacing", ncyc, 2);
      check("t3_addr", bus.pmem_address, exp_i ? 32'h1000 : 32'h2000);
      bus.pmem_resp = 1'b1;
      #2;
      check("t3_i_resp", bus.i_resp, exp_i);
      check("t3_d_resp", bus.d_resp, !exp_i);
      nxt();
      bus.pmem_resp = 1'b0;
    end
    bus.i_read = 1'b0;
    bus.d_read = 1'b0;
    nxt();

    // D read address stays latched while d_address changes
    bus.d_read = 1'b1;
    bus.d_address = 32'h400;
    nxt(); settle();
    check("t4_read", bus.pmem_read, 1'b1);
    check("t4_addr0", bus.pmem_address, 32'h400);
    bus.d_address = 32'h800;
    nxt(); settle();
    check("t4_addr1", bus.pmem_address, 32'h400);
    nxt();
    bus.pmem_resp = 1'b1;
    settle();
    check("t4_addr2", bus.pmem_address, 32'h400);
    check("t4_d_resp", bus.d_resp, 1'b1);
    nxt();
    bus.pmem_resp = 1'b0;
    bus.d_read = 1'b0;
    nxt();

    // Reset two cycles into SERVE_D
    bus.d_write = 1'b1;
    bus.d_address = 32'h300;
    bus.d_wdata = line_a5;
    nxt(); settle();
    check("t5_write", bus.pmem_write, 1'b1);
    nxt();
    rst = 1'b1;
    bus.d_write = 1'b0;
    nxt(); settle();
    check("t5_rst_busy", bus.arb_busy, 1'b0);
    check("t5_rst_write", bus.pmem_write, 1'b0);
    check("t5_rst_read", bus.pmem_read, 1'b0);
    rst = 1'b0;
    bus.i_read = 1'b1;
    bus.i_address = 32'h500;
    bus.d_read = 1'b1;
    bus.d_address = 32'h600;
    nxt(); settle();
    check("t5_i_wins", bus.pmem_address, 32'h500);
    bus.pmem_resp = 1'b1;
    #2;
    check("t5_i_resp", bus.i_resp, 1'b1);
    nxt();
    bus.pmem_resp = 1'b0;
    bus.i_read = 1'b0;
    bus.d_read = 1'b0;
    nxt();

    // Spurious pmem_resp in IDLE
    bus.pmem_resp = 1'b1;
    settle();
    check("t6_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    check("t6_busy", bus.arb_busy, 1'b0);
    nxt(); settle();
    check("t6_busy_after", bus.arb_busy, 1'b0);
    check("t6_strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);
    bus.pmem_resp = 1'b0;

    // last_grant was I before this reset; reset must restore the D value
    do_reset();
    bus.i_read = 1'b1;
    bus.i_address = 32'h900;
    bus.d_read = 1'b1;
    bus.d_address = 32'hA00;
    nxt(); settle();
    check("t7_i_after_rst", bus.pmem_address, 32'h900);
    bus.pmem_resp = 1'b1;
    #2;
    check("t7_i_resp", bus.i_resp, 1'b1);
    nxt();
    idle_inputs();
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
